// File: rtl/wd_fail_responder.sv
`default_nettype none
// ============================================================================
// Module      : wd_fail_responder
// Description : Consumes watchdog fail-detector verdicts (WDFAIL / FLSTAT),
//               synchronises them, evaluates once per SWSTAT period, tracks
//               consecutive and total failures, escalates NORMAL -> WARN ->
//               SAFE, and after operator ACK issues a timed SYSRST pulse.
//               Optional macro FLT_HISTORY_EN adds HIST[7:0], a 4-deep
//               history of counted fault codes.
// Revision    : 1.0 - initial release
// ============================================================================
module wd_fail_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int WARN_LIMIT  = 2,
  parameter int SAFE_LIMIT  = 4,
  parameter int RST_PULSE   = 16,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SWSTAT,
  input  logic             WDFAIL,
  input  logic [1:0]       FLSTAT,
  input  logic             ACK,
  output logic             WARN,
  output logic             SAFEST,
  output logic             SYSRST,
  output logic [CNT_W-1:0] FAULTCNT,
  output logic [1:0]       LASTFL
`ifdef FLT_HISTORY_EN
  ,
  output logic [7:0]       HIST
`endif
);

  localparam int CONSEC_W = $clog2(SAFE_LIMIT + 1);
  localparam int PULSE_W  = $clog2(RST_PULSE + 1);

  localparam logic [CONSEC_W-1:0] WARN_LIM   = CONSEC_W'(WARN_LIMIT);
  localparam logic [CONSEC_W-1:0] SAFE_LIM   = CONSEC_W'(SAFE_LIMIT);
  localparam logic [PULSE_W-1:0]  PULSE_LAST = PULSE_W'(RST_PULSE - 1);

  localparam logic [1:0] FL_OVERRIDE  = 2'b01;
  localparam logic [1:0] FL_NOSERVICE = 2'b11;

  typedef enum logic [1:0] {
    S_NORMAL = 2'd0,
    S_WARN   = 2'd1,
    S_SAFE   = 2'd2,
    S_RESET  = 2'd3
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0]      swstat_sync;
  logic [SYNC_STAGES-1:0]      wdfail_sync;
  logic [SYNC_STAGES-1:0][1:0] flstat_sync;
  logic                        swstat_prev;

  logic [CONSEC_W-1:0] consec, consec_n;
  logic [PULSE_W-1:0]  pulse_cnt, pulse_cnt_n;
  logic [CNT_W-1:0]    faultcnt_n;
  logic [1:0]          lastfl_n;
`ifdef FLT_HISTORY_EN
  logic [7:0]          hist_n;
`endif

  logic       strobe;
  logic       fail_s;
  logic [1:0] code_s;

  assign strobe = swstat_sync[SYNC_STAGES-1] & ~swstat_prev;
  assign fail_s = wdfail_sync[SYNC_STAGES-1];
  assign code_s = flstat_sync[SYNC_STAGES-1];

  // Multi-flop synchronisers for the asynchronous detector inputs, plus the
  // delayed SWSTAT copy used for rising-edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      swstat_sync <= '0;
      wdfail_sync <= '0;
      flstat_sync <= '0;
      swstat_prev <= 1'b0;
    end else begin
      swstat_sync <= {swstat_sync[SYNC_STAGES-2:0], SWSTAT};
      wdfail_sync <= {wdfail_sync[SYNC_STAGES-2:0], WDFAIL};
      flstat_sync <= {flstat_sync[SYNC_STAGES-2:0], FLSTAT};
      swstat_prev <= swstat_sync[SYNC_STAGES-1];
    end
  end

  // State register; every output is a flop loaded from the next-state decode.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_NORMAL;
      consec    <= '0;
      pulse_cnt <= '0;
      FAULTCNT  <= '0;
      LASTFL    <= 2'b00;
      WARN      <= 1'b0;
      SAFEST    <= 1'b0;
      SYSRST    <= 1'b0;
`ifdef FLT_HISTORY_EN
      HIST      <= 8'h00;
`endif
    end else begin
      state     <= state_n;
      consec    <= consec_n;
      pulse_cnt <= pulse_cnt_n;
      FAULTCNT  <= faultcnt_n;
      LASTFL    <= lastfl_n;
      WARN      <= (state_n == S_WARN);
      SAFEST    <= (state_n == S_SAFE) || (state_n == S_RESET);
      SYSRST    <= (state_n == S_RESET);
`ifdef FLT_HISTORY_EN
      HIST      <= hist_n;
`endif
    end
  end

  // Evaluation datapath and escalation FSM; ACK outranks a same-cycle strobe.
  always_comb begin
    state_n     = state;
    consec_n    = consec;
    pulse_cnt_n = pulse_cnt;
    faultcnt_n  = FAULTCNT;
    lastfl_n    = LASTFL;
`ifdef FLT_HISTORY_EN
    hist_n      = HIST;
`endif
    case (state)
      S_NORMAL, S_WARN: begin
        if (ACK) begin
          consec_n = '0;
          state_n  = S_NORMAL;
        end else if (strobe) begin
          if (!fail_s) begin
            consec_n = '0;
            state_n  = S_NORMAL;
          end else begin
            if (FAULTCNT != '1) faultcnt_n = FAULTCNT + CNT_W'(1);
            lastfl_n = code_s;
`ifdef FLT_HISTORY_EN
            hist_n   = {HIST[5:0], code_s};
`endif
            if (code_s != FL_OVERRIDE && consec != SAFE_LIM)
              consec_n = consec + CONSEC_W'(1);
            if (code_s == FL_NOSERVICE)
              state_n = S_SAFE;
            else if (state == S_WARN && consec_n >= SAFE_LIM)
              state_n = S_SAFE;
            else if (state == S_NORMAL && consec_n >= WARN_LIM)
              state_n = S_WARN;
          end
        end
      end
      S_SAFE: begin
        if (ACK) begin
          state_n     = S_RESET;
          pulse_cnt_n = '0;
        end
      end
      S_RESET: begin
        if (pulse_cnt == PULSE_LAST) begin
          state_n     = S_NORMAL;
          consec_n    = '0;
          pulse_cnt_n = '0;
        end else begin
          pulse_cnt_n = pulse_cnt + PULSE_W'(1);
        end
      end
      default: state_n = S_NORMAL;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_wd_fail_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_wd_fail_responder
// Description : Directed self-checking bench for wd_fail_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wd_fail_responder;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SWSTAT = 1'b0;
  logic       WDFAIL = 1'b0;
  logic [1:0] FLSTAT = 2'b00;
  logic       ACK = 1'b0;
  logic       WARN, SAFEST, SYSRST;
  logic [7:0] FAULTCNT;
  logic [1:0] LASTFL;
`ifdef FLT_HISTORY_EN
  logic [7:0] HIST;
`endif

  int checks = 0;
  int errors = 0;

  wd_fail_responder #(
    .SYNC_STAGES(2), .WARN_LIMIT(2), .SAFE_LIMIT(4), .RST_PULSE(16), .CNT_W(8)
  ) dut (
    .CLK(CLK), .RST(RST), .SWSTAT(SWSTAT), .WDFAIL(WDFAIL), .FLSTAT(FLSTAT),
    .ACK(ACK), .WARN(WARN), .SAFEST(SAFEST), .SYSRST(SYSRST),
    .FAULTCNT(FAULTCNT), .LASTFL(LASTFL)
`ifdef FLT_HISTORY_EN
    , .HIST(HIST)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SWSTAT period carrying a verdict; ends after the evaluation has landed.
  task automatic period(input logic wf, input logic [1:0] fl);
    @(negedge CLK);
    WDFAIL = wf;
    FLSTAT = fl;
    SWSTAT = 1'b1;
    repeat (4) @(negedge CLK);
    SWSTAT = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic ack_pulse();
    @(negedge CLK);
    ACK = 1'b1;
    @(negedge CLK);
    ACK = 1'b0;
  endtask

  // Counts negedge samples with SYSRST high; called right after ack_pulse.
  task automatic measure_pulse(output int n);
    n = 0;
    while (SYSRST === 1'b1 && n < 64) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  int plen;

  initial begin
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_warn",   WARN,     0);
    chk("rst_safest", SAFEST,   0);
    chk("rst_sysrst", SYSRST,   0);
    chk("rst_cnt",    FAULTCNT, 0);
    chk("rst_lastfl", LASTFL,   0);

    // Passing periods leave everything idle.
    repeat (3) period(1'b0, 2'b00);
    chk("pass_warn",   WARN,     0);
    chk("pass_safest", SAFEST,   0);
    chk("pass_cnt",    FAULTCNT, 0);
    chk("pass_lastfl", LASTFL,   0);

    // Two multiple-service fails reach WARN; evaluation lands on the 3rd edge.
    period(1'b1, 2'b10);
    chk("f1_warn", WARN,     0);
    chk("f1_cnt",  FAULTCNT, 1);
    @(negedge CLK);
    WDFAIL = 1'b1; FLSTAT = 2'b10; SWSTAT = 1'b1;
    repeat (2) @(negedge CLK);
    chk("f2_warn_early", WARN, 0);
    @(negedge CLK);
    chk("f2_warn_edge", WARN, 1);
    SWSTAT = 1'b0;
    repeat (4) @(negedge CLK);
    chk("f2_cnt",    FAULTCNT, 2);
    chk("f2_lastfl", LASTFL,   2'b10);
    period(1'b0, 2'b00);
    chk("pass_clr_warn", WARN,     0);
    chk("pass_clr_cnt",  FAULTCNT, 2);

    // Four consecutive fails escalate to SAFE; ACK yields a 16-cycle pulse.
    do_reset();
    period(1'b1, 2'b10);
    period(1'b1, 2'b10);
    period(1'b1, 2'b10);
    chk("f3_warn",   WARN,   1);
    chk("f3_safest", SAFEST, 0);
    period(1'b1, 2'b10);
    chk("f4_safest", SAFEST,   1);
    chk("f4_warn",   WARN,     0);
    chk("f4_cnt",    FAULTCNT, 4);
    period(1'b1, 2'b11);
    chk("safe_ignore_cnt",    FAULTCNT, 4);
    chk("safe_ignore_lastfl", LASTFL,   2'b10);
    ack_pulse();
    chk("pulse_safest", SAFEST, 1);
    measure_pulse(plen);
    chk("pulse_len",      plen,     16);
    chk("post_safest",    SAFEST,   0);
    chk("post_warn",      WARN,     0);
    chk("post_cnt",       FAULTCNT, 4);
    chk("post_lastfl",    LASTFL,   2'b10);

    // No-service fault jumps straight to SAFE; override never escalates.
    period(1'b1, 2'b11);
    chk("ns_safest", SAFEST,   1);
    chk("ns_lastfl", LASTFL,   2'b11);
    chk("ns_cnt",    FAULTCNT, 5);
    ack_pulse();
    measure_pulse(plen);
    chk("ns_pulse_len", plen, 16);
    repeat (5) period(1'b1, 2'b01);
    chk("ovr_cnt",    FAULTCNT, 10);
    chk("ovr_warn",   WARN,     0);
    chk("ovr_safest", SAFEST,   0);
    chk("ovr_lastfl", LASTFL,   2'b01);

    // ACK coincident with a failing strobe in WARN discards the evaluation.
    period(1'b1, 2'b10);
    period(1'b1, 2'b10);
    chk("w_warn", WARN,     1);
    chk("w_cnt",  FAULTCNT, 12);
    @(negedge CLK);
    WDFAIL = 1'b1; FLSTAT = 2'b11; SWSTAT = 1'b1;
    repeat (2) @(negedge CLK);
    ACK = 1'b1;
    @(negedge CLK);
    ACK = 1'b0;
    SWSTAT = 1'b0;
    repeat (4) @(negedge CLK);
    chk("ackev_warn",   WARN,     0);
    chk("ackev_safest", SAFEST,   0);
    chk("ackev_cnt",    FAULTCNT, 12);
    chk("ackev_lastfl", LASTFL,   2'b10);
    period(1'b1, 2'b10);
    chk("ackev_consec_clr", WARN, 0);
    chk("ackev_cnt2", FAULTCNT, 13);

    // Reset asserted mid-pulse drops SYSRST without waiting for a clock edge.
    period(1'b1, 2'b11);
    ack_pulse();
    repeat (4) @(negedge CLK);
    chk("mid_sysrst_pre", SYSRST, 1);
    RST = 1'b1;
    #1;
    chk("mid_sysrst", SYSRST,   0);
    chk("mid_safest", SAFEST,   0);
    chk("mid_warn",   WARN,     0);
    chk("mid_cnt",    FAULTCNT, 0);
    chk("mid_lastfl", LASTFL,   0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

`ifdef FLT_HISTORY_EN
    period(1'b1, 2'b10);
    period(1'b1, 2'b11);
    ack_pulse();
    measure_pulse(plen);
    period(1'b1, 2'b01);
    period(1'b1, 2'b10);
    chk("hist", HIST, 8'b10_11_01_10);
    do_reset();
    chk("hist_rst", HIST, 8'h00);
`endif

    // Total-fault counter saturates at all ones.
    repeat (258) period(1'b1, 2'b01);
    chk("sat_cnt",  FAULTCNT, 8'd255);
    chk("sat_warn", WARN,     0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
